// File: rtl/mux_16x1_pkg.sv
// mux_16x1_pkg: constants, types and helper functions shared by the 16:1
// mux, its 4:1 building block and the testbench.
//   N_IN   number of data lanes (16)
//   SEL_W  select width (4)
//   GRP    lanes per first-level group (4)
package mux_16x1_pkg;

  localparam int unsigned N_IN  = 16;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned GRP   = 4;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_IN-1:0]  onehot_t;

  // One-hot decode: exactly bit s set for every legal code.
  function automatic onehot_t sel_to_onehot(input sel_t s);
    return onehot_t'(1) << s;
  endfunction

  // Low select bits pick a lane inside a group of four.
  function automatic logic [1:0] sel_lane(input sel_t s);
    return s[1:0];
  endfunction

  // High select bits pick the group.
  function automatic logic [1:0] sel_group(input sel_t s);
    return s[3:2];
  endfunction

endpackage

// File: rtl/mux_16x1_mux_4x1.sv
// mux_4x1: combinational 4:1 lane selector used as the tree element.
// Ports:
//   in   [4*WIDTH-1:0]  four lanes, lane k at [k*WIDTH +: WIDTH]
//   sel  [1:0]          lane select
//   y    [WIDTH-1:0]    selected lane
module mux_4x1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [4*WIDTH-1:0] in,
  input  logic [1:0]         sel,
  output logic [WIDTH-1:0]   y
);

  function automatic logic [WIDTH-1:0] pick4(input logic [4*WIDTH-1:0] v,
                                             input logic [1:0]         s);
    return WIDTH'(v >> (32'(s) * WIDTH));
  endfunction

  always_comb begin
    y = pick4(in, sel);
  end

endmodule

// File: rtl/mux_16x1.sv
// mux_16x1: 16-lane WIDTH-bit multiplexer with one-hot select decode and
// an optional registered output stage.
// Configuration macro: MUX_16X1_REG_OUT_EN
//   defined   -> y_q/y_q_vld are registered (sync active-low reset, load on en)
//   undefined -> y_q follows y combinationally, y_q_vld tied high; clk, rst_n
//                and en are ignored (port list identical in both builds)
// Ports:
//   clk      sole clock, rising edge
//   rst_n    synchronous active-low reset of y_q / y_q_vld
//   en       load enable for the output register
//   in       16 lanes, lane k at [k*WIDTH +: WIDTH]
//   sel      lane select 0..15
//   y        selected lane (combinational)
//   sel_oh   one-hot decode of sel (combinational)
//   y_q      registered copy of y
//   y_q_vld  y_q holds a value loaded since the last reset
module mux_16x1
  import mux_16x1_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [N_IN*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      y,
  output logic [N_IN-1:0]       sel_oh,
  output logic [WIDTH-1:0]      y_q,
  output logic                  y_q_vld
);

  // Reference lane choice; the tree below must agree with it bit for bit.
  function automatic logic [WIDTH-1:0] lane_pick(input logic [N_IN*WIDTH-1:0] v,
                                                 input sel_t                  s);
    return WIDTH'(v >> (32'(s) * WIDTH));
  endfunction

  logic [GRP*WIDTH-1:0] l1_bus;
  logic [WIDTH-1:0]     y_tree;

  // First level: four groups of four lanes, all on sel[1:0].
  for (genvar g = 0; g < GRP; g++) begin : g_l1
    mux_4x1 #(.WIDTH(WIDTH)) u_l1 (
      .in  (in[g*GRP*WIDTH +: GRP*WIDTH]),
      .sel (sel_lane(sel)),
      .y   (l1_bus[g*WIDTH +: WIDTH])
    );
  end

  // Second level: choose the group on sel[3:2].
  mux_4x1 #(.WIDTH(WIDTH)) u_l2 (
    .in  (l1_bus),
    .sel (sel_group(sel)),
    .y   (y_tree)
  );

  always_comb begin
    y      = y_tree;
    sel_oh = sel_to_onehot(sel);
    assert (y_tree == lane_pick(in, sel));
  end

`ifdef MUX_16X1_REG_OUT_EN
  // Reset has priority over en on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q     <= '0;
      y_q_vld <= 1'b0;
    end else if (en) begin
      y_q     <= y;
      y_q_vld <= 1'b1;
    end
  end
`else
  logic unused_ctrl;
  assign unused_ctrl = &{1'b0, clk, rst_n, en};

  always_comb begin
    y_q     = y;
    y_q_vld = 1'b1;
  end
`endif

endmodule

// File: tb/tb_mux_16x1.sv
// tb_mux_16x1: self-checking bench for mux_16x1 (WIDTH=1 and WIDTH=8
// instances sharing control). Expected values come from a lane-extraction
// model working bit by bit on the input vectors plus a small registered-stage
// model; both builds of MUX_16X1_REG_OUT_EN are covered by the same bench.
module tb_mux_16x1;

  localparam int unsigned WW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [3:0]        sel;
  logic [15:0]       in1;
  logic [16*WW-1:0]  inw;

  logic              y1, yq1, v1;
  logic [15:0]       oh1;
  logic [WW-1:0]     yw, yqw;
  logic [15:0]       ohw;
  logic              vw;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // model of the output stage
  logic [63:0] eq1, eqw;
  logic        ev;

  always #5 clk = ~clk;

  mux_16x1 #(.WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in1), .sel(sel),
    .y(y1), .sel_oh(oh1), .y_q(yq1), .y_q_vld(v1)
  );

  mux_16x1 #(.WIDTH(WW)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .in(inw), .sel(sel),
    .y(yw), .sel_oh(ohw), .y_q(yqw), .y_q_vld(vw)
  );

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Lane k of a packed vector with w-bit lanes, gathered bit by bit.
  function automatic logic [63:0] ref_lane(input logic [16*WW-1:0] v,
                                           input int unsigned k,
                                           input int unsigned w);
    logic [63:0] r;
    r = '0;
    for (int unsigned b = 0; b < w; b++) r[b] = v[k*w + b];
    return r;
  endfunction

  function automatic logic [63:0] exp_n();
    return ref_lane({{(16*WW-16){1'b0}}, in1}, int'(sel), 1);
  endfunction

  function automatic logic [63:0] exp_w();
    return ref_lane(inw, int'(sel), WW);
  endfunction

  task automatic check_comb(input string tag);
    logic [15:0] one;
    one = 16'h0001;
    check_eq({tag, ".y"},      64'(y1),  exp_n());
    check_eq({tag, ".yw"},     64'(yw),  exp_w());
    check_eq({tag, ".oh"},     64'(oh1), 64'(one << sel));
    check_eq({tag, ".ohw"},    64'(ohw), 64'(one << sel));
    check_eq({tag, ".ohcnt"},  64'($countones(oh1)), 64'd1);
  endtask

  // One clock: advance the model using the inputs presented before the edge,
  // then sample #1 after the edge.
  task automatic tick(input string tag);
`ifdef MUX_16X1_REG_OUT_EN
    if (!rst_n) begin
      eq1 = '0; eqw = '0; ev = 1'b0;
    end else if (en) begin
      eq1 = exp_n(); eqw = exp_w(); ev = 1'b1;
    end
`endif
    @(posedge clk);
    #1;
`ifndef MUX_16X1_REG_OUT_EN
    eq1 = exp_n(); eqw = exp_w(); ev = 1'b1;
`endif
    check_eq({tag, ".yq"},   64'(yq1), eq1);
    check_eq({tag, ".yqw"},  64'(yqw), eqw);
    check_eq({tag, ".vld"},  64'(v1),  64'(ev));
    check_eq({tag, ".vldw"}, 64'(vw),  64'(ev));
  endtask

  task automatic rand_wide();
    for (int unsigned i = 0; i < 16*WW/32; i++) inw[i*32 +: 32] = $urandom;
  endtask

  initial begin
    int sweep_exp[16];
    sweep_exp = '{0,1,0,1,0,0,0,0,1,1,1,1,0,1,0,1};
    eq1 = '0; eqw = '0; ev = 1'b0;
    rst_n = 1'b1;
    en    = 1'b0;
    sel   = 4'd0;
    in1   = 16'b1010111100001010;
    rand_wide();
    @(posedge clk);
    #1;

    // fixed-pattern sweep, 10 time units per step
    for (int i = 0; i < 16; i++) begin
      sel = 4'(i);
      #1;
      check_eq("sweep.y", 64'(y1), 64'(sweep_exp[i]));
      check_comb("sweep");
`ifndef MUX_16X1_REG_OUT_EN
      check_eq("sweep.yq_comb", 64'(yq1), 64'(sweep_exp[i]));
      check_eq("sweep.vld_comb", 64'(v1), 64'd1);
`endif
      #9;
    end

    // reset for two cycles with en=1 and y=1, then load lane 1
    sel = 4'd1; en = 1'b1; rst_n = 1'b0;
    #1;
    check_eq("rst.y_live", 64'(y1), 64'd1);
    tick("rst0");
    tick("rst1");
    rst_n = 1'b1;
    tick("load1");
    check_eq("load1.yq_is1", 64'(yq1), 64'd1);

    // en=0, switch to lane 4: y follows at once, y_q holds
    en = 1'b0; sel = 4'd4;
    #1;
    check_eq("hold.y_now", 64'(y1), 64'd0);
    for (int c = 0; c < 3; c++) tick("hold");

    // reset wins over en on the same edge
    en = 1'b1; sel = 4'd1; rst_n = 1'b0;
    tick("rst_vs_en");
    rst_n = 1'b1;

    // randomized traffic; inputs change every cycle so each capture uses the
    // pre-edge value
    for (int i = 0; i < 300; i++) begin
      in1   = 16'($urandom);
      rand_wide();
      sel   = 4'($urandom_range(0, 15));
      en    = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 15) != 0);
      #1;
      check_comb("rand");
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_16x1.md
MUX_16X1 -- requirements
Module: mux_16x1

Interface
REQ-001 Parameter WIDTH, default 1, bit width of each of the 16 data lanes.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled only on rising clk.
REQ-004 en  input  1  load enable for the registered output stage.
REQ-005 in  input  16*WIDTH  data lanes; lane k occupies bits [k*WIDTH +: WIDTH].
REQ-006 sel  input  4  lane select, unsigned 0..15.
REQ-007 y  output  WIDTH  combinational selected lane.
REQ-008 sel_oh  output  16  combinational one-hot decode of sel.
REQ-009 y_q  output  WIDTH  registered copy of y.
REQ-010 y_q_vld  output  1  high when y_q holds a value loaded since the last reset.

Function
REQ-011 y SHALL equal lane sel of in at all times: pure combinational, zero latency, no latches, reacting to any change of in or sel.
REQ-012 The lane choice SHALL be computed by a Verilog function taking (in, sel) and returning WIDTH bits.
REQ-013 sel_oh SHALL have exactly bit sel set, for all 16 sel values.
REQ-014 All 16 sel codes are legal; there is no out-of-range case and no X output for known inputs.
REQ-015 With en=1 at a rising clk and rst_n=1, y_q SHALL load y and y_q_vld SHALL go to 1: one-cycle latency.
REQ-016 With en=0, y_q and y_q_vld SHALL hold.
REQ-017 If sel or in change in the same cycle as en=1, y_q SHALL capture the value of y presented just before the edge.
REQ-018 Lanes not selected SHALL have no effect on y or y_q.

Reset
REQ-019 While rst_n=0 at a rising clk, y_q SHALL clear to 0 and y_q_vld SHALL clear to 0, regardless of en.
REQ-020 Reset SHALL NOT affect y or sel_oh; they remain combinational functions of in and sel.
REQ-021 Reset asserted mid-operation SHALL win over en on the same edge.

Configuration
REQ-022 Macro MUX_16X1_REG_OUT_EN defined: the registered stage (REQ-015 to REQ-017, REQ-019) SHALL be present.
REQ-023 Macro MUX_16X1_REG_OUT_EN undefined: y_q SHALL be wired to y combinationally and y_q_vld SHALL be tied to 1.
REQ-024 Without the macro, clk, rst_n and en SHALL be ignored; the port list SHALL be identical in both builds.

Structure
REQ-025 Package mux_16x1_pkg SHALL hold N_IN=16, SEL_W=4 and the select/one-hot functions shared with the bench.
REQ-026 The datapath SHALL be a two-level tree of five mux_4x1 sub-modules:
- four first-level instances on sel[1:0];
- one second-level instance on sel[3:2];
- mux_4x1 internally uses a task or function for lane selection.
REQ-027 The tree result SHALL be bit-identical to the function result of REQ-012.

Verification
REQ-028 Sweep with WIDTH=1, in=16'b1010111100001010, sel swept 0..15, 10 time units apart -> y=0,1,0,1,0,0,0,0,1,1,1,1,0,1,0,1.
REQ-029 Same sweep -> sel_oh=16'h0001<<sel, exactly one bit set at every step.
REQ-030 rst_n=0 for 2 cycles with en=1 and y=1 -> y_q=0 and y_q_vld=0; then rst_n=1, en=1, sel=1 -> next edge y_q=1 and y_q_vld=1.
REQ-031 en=0 and sel changed from 1 to 4 -> y becomes 0 immediately; y_q stays 1 for 3 cycles.
REQ-032 rst_n=0 and en=1 on the same edge -> y_q=0 and y_q_vld=0.
REQ-033 Build without MUX_16X1_REG_OUT_EN -> y_q tracks y with zero delay and y_q_vld=1 at all times, including during rst_n=0.
